// File: rtl/rv32i_bus_pkg.sv
// rv32i_bus_pkg: shared bus target IDs, UART register map, STATUS bits, RamMode bits and load extension
package rv32i_bus_pkg;
  typedef enum logic {BUS_RAM = 1'b0, BUS_UART = 1'b1} bus_target_t;
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam int ST_TX_NOT_FULL = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_OVF = 3;
  localparam int MODE_BYTE = 3;
  localparam int MODE_HALF = 2;
  localparam int MODE_WORD = 1;
  localparam int MODE_UNSIGNED = 0;
  // Pick the addressed byte/half out of a little-endian word and sign/zero-extend it.
  function automatic logic [31:0] loadExtend(input logic [31:0] w, input logic [1:0] off, input logic [3:0] mode);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    return mode[MODE_BYTE] ? {{24{b[7] & ~mode[MODE_UNSIGNED]}}, b} :
           mode[MODE_HALF] ? {{16{h[15] & ~mode[MODE_UNSIGNED]}}, h} : w;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; push accepted when not full or when popping in the same cycle
// Ports: clk, rstB (sync, active low), push/wrData in, pop in, rdData = head, full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstB,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  always_comb begin
    empty = wrPtr == rdPtr;
    full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    doPop = pop & ~empty;
    doPush = push & (~full | doPop);
    rdData = mem[rdPtr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (!rstB) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      wrPtr <= wrPtr + {{AW{1'b0}}, doPush};
      rdPtr <= rdPtr + {{AW{1'b0}}, doPop};
    end
  end
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end
endmodule

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: RV32I load/store interconnect steering accesses to sync RAM or the UART window
// Ports: core side addr/dataBusOut/wrEn/rdEn/RamMode in, dataBusIn/dataBusInEn out (2-cycle loads);
//        RAM side ram_addr/ram_wdata/ram_be/ram_we/ram_re out, ram_rdata in;
//        UART side uart_tx_data/uart_tx_valid out, uart_tx_ready in, uart_rx_data/uart_rx_valid in,
//        uart_rx_pop out; bus_err pulses on misaligned or unmapped accesses.
module data_bus_ctrl
  import rv32i_bus_pkg::*;
#(
  parameter int          RAM_AW    = 10,
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] UART_BASE = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic [31:0]       addr,
  input  logic [31:0]       dataBusOut,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [3:0]        RamMode,
  output logic [31:0]       dataBusIn,
  output logic              dataBusInEn,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_pop,
  output logic              bus_err
);
  logic wr, rd, isRam, isUart, misal, ok;
  logic txPush, txPop, txFull, txEmpty, txOvf, stsWr;
  logic [3:0] off;
  logic [7:0] txHead;
  logic [31:0] status, uartRd;
  logic p1Valid, p1Zero;
  bus_target_t p1Tgt;
  logic [1:0] p1Off;
  logic [3:0] p1Mode;
  logic [31:0] p1Data;
  always_comb begin
    // Requests are ignored while in reset; a simultaneous store wins over a load.
    wr = wrEn & rstB;
    rd = rdEn & rstB & ~wrEn;
    isRam = addr < (32'd4 << RAM_AW);
    isUart = addr[31:4] == UART_BASE[31:4];
    off = addr[3:0];
    misal = (RamMode[MODE_HALF] & addr[0]) | (RamMode[MODE_WORD] & |addr[1:0]);
    ok = ~misal & (isRam | isUart);
    bus_err = (wr | rd) & ~ok;
    ram_we = wr & ok & isRam;
    ram_re = rd & ok & isRam;
    ram_be = ~ram_we ? 4'b0000 : RamMode[MODE_BYTE] ? 4'b0001 << addr[1:0] :
             RamMode[MODE_HALF] ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ram_wdata = ~ram_we ? 32'h0 : RamMode[MODE_BYTE] ? {4{dataBusOut[7:0]}} :
                RamMode[MODE_HALF] ? {2{dataBusOut[15:0]}} : dataBusOut;
    ram_addr = (ram_we | ram_re) ? addr[RAM_AW+1:2] : '0;
    txPush = wr & ok & isUart & (off == OFF_TXDATA);
    stsWr = wr & ok & isUart & (off == OFF_STATUS);
    txPop = ~txEmpty & uart_tx_ready;
    uart_tx_valid = ~txEmpty;
    uart_tx_data = txEmpty ? 8'h00 : txHead;
    uart_rx_pop = rd & ok & isUart & (off == OFF_RXDATA) & uart_rx_valid;
    status = '0;
    status[ST_TX_NOT_FULL] = ~txFull;
    status[ST_RX_VALID] = uart_rx_valid;
    status[ST_TX_EMPTY] = txEmpty;
    status[ST_TX_OVF] = txOvf;
    // UART registers are sampled in the request cycle so the pop and the data stay paired.
    uartRd = off == OFF_RXDATA ? {24'h0, uart_rx_data} : off == OFF_STATUS ? status : 32'h0;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
    .clk(clk),
    .rstB(rstB),
    .push(txPush),
    .pop(txPop),
    .wrData(dataBusOut[7:0]),
    .rdData(txHead),
    .full(txFull),
    .empty(txEmpty)
  );
  always_ff @(posedge clk) begin
    if (!rstB) begin
      p1Valid <= 1'b0;
      p1Zero <= 1'b0;
      p1Tgt <= BUS_RAM;
      p1Off <= '0;
      p1Mode <= '0;
      p1Data <= '0;
      dataBusInEn <= 1'b0;
      dataBusIn <= '0;
      txOvf <= 1'b0;
    end else begin
      p1Valid <= rd;
      p1Zero <= ~ok;
      p1Tgt <= isUart ? BUS_UART : BUS_RAM;
      p1Off <= addr[1:0];
      p1Mode <= RamMode;
      p1Data <= uartRd;
      dataBusInEn <= p1Valid;
      dataBusIn <= ~p1Valid | p1Zero ? 32'h0 :
                   loadExtend(p1Tgt == BUS_RAM ? ram_rdata : p1Data, p1Off, p1Mode);
      txOvf <= stsWr ? 1'b0 : (txPush & txFull & ~txPop) ? 1'b1 : txOvf;
    end
  end
endmodule
